// File: rtl/queue_push_arbiter.sv
// Purpose: round-robin arbiter sharing one Queue push port among Requesters producers, bounded bursts.
// Latency: owner's first word pushes on the cycle grant rises; one idle bubble between grants.
// Backpressure: q_full stalls the owner (no push, grant and count hold). QUEUE_ARB_HIPRI_EN gives requester 0 priority.
module queue_push_arbiter #(
    parameter int Requesters = 4,
    parameter int Width      = 8,
    parameter int MaxBurst   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [Requesters-1:0]         req,
    input  logic [Requesters*Width-1:0]   data,
    output logic [Requesters-1:0]         ack,
    output logic [Requesters-1:0]         grant,
    output logic                          busy,
    output logic                          q_push,
    output logic [Width-1:0]              q_data,
    input  logic                          q_full
);

    localparam int PtrW = (Requesters > 1) ? $clog2(Requesters) : 1;
    localparam int CntW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state_q, state_d;
    logic [Requesters-1:0]   grant_q, grant_d;
    logic [PtrW-1:0]         ptr_q, ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [PtrW-1:0]         owner;
    logic [PtrW-1:0]         ptr_nxt;
    logic [PtrW-1:0]         win;
    logic                    win_vld;

    always_comb begin
        owner = '0;
        for (int i = 0; i < Requesters; i++) begin
            if (grant_q[i]) owner = PtrW'(i);
        end
    end

    // Scan downwards so the requester closest to ptr (wrapping) is the last assignment.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        for (int k = Requesters - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % Requesters;
            if (req[idx]) begin
                win_vld = 1'b1;
                win     = PtrW'(idx);
            end
        end
`ifdef QUEUE_ARB_HIPRI_EN
        if (req[0]) begin
            win_vld = 1'b1;
            win     = '0;
        end
`endif
    end

    assign ptr_nxt = (int'(owner) == Requesters - 1) ? '0 : PtrW'(int'(owner) + 1);

    assign busy   = (state_q == BURST);
    assign grant  = grant_q;
    assign q_push = busy & req[owner] & ~q_full;
    assign q_data = busy ? data[int'(owner)*Width +: Width] : '0;
    assign ack    = q_push ? (Requesters'(1) << owner) : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BURST;
                    grant_d = Requesters'(1) << win;
                    count_d = '0;
                end
            end
            BURST: begin
                if (!req[owner] || (q_push && count_q == CntW'(MaxBurst - 1))) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_nxt;
                end else if (q_push) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_queue_push_arbiter.sv
// Directed bench for queue_push_arbiter with a depth-4 Queue model and per-producer word tables.
module tb_queue_push_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        q_push;
    logic [7:0]  q_data;
    logic        q_full;

    logic [3:0]  en;
    int          wi [4];
    int          nw [4];
    logic [7:0]  words [4][8];
    logic [7:0]  fifo [$];
    logic [7:0]  plog [$];
    int          fcnt;
    logic        pull;
    int          passed;
    int          total;
    int          failed;
    logic [3:0]  exp6;

    queue_push_arbiter #(.Requesters(4), .Width(8), .MaxBurst(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data   (data),
        .ack    (ack),
        .grant  (grant),
        .busy   (busy),
        .q_push (q_push),
        .q_data (q_data),
        .q_full (q_full)
    );

    always #5 clk = ~clk;

    assign q_full = (fcnt >= 4);

    always_comb begin
        req  = '0;
        data = '0;
        for (int i = 0; i < 4; i++) begin
            req[i]          = en[i] && (wi[i] < nw[i]);
            data[i*8 +: 8]  = words[i][wi[i] & 7];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture the handshake of the current cycle, cross the edge, then update the models.
    task automatic tick();
        logic [3:0] s_ack;
        logic       s_push;
        logic       s_pull;
        logic [7:0] s_dat;
        #1;
        s_ack  = ack;
        s_push = q_push;
        s_dat  = q_data;
        s_pull = pull && (fcnt > 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (s_ack[i]) wi[i]++;
        end
        if (s_pull) void'(fifo.pop_front());
        if (s_push) begin
            fifo.push_back(s_dat);
            plog.push_back(s_dat);
        end
        fcnt = fifo.size();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_models();
        fifo.delete();
        plog.delete();
        fcnt = 0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        failed = 0;
        pull   = 1'b0;
        fcnt   = 0;
        for (int k = 0; k < 8; k++) begin
            words[0][k] = 8'h01 + 8'(k);
            words[1][k] = 8'h00;
            words[2][k] = 8'h21 + 8'(k);
            words[3][k] = 8'h31 + 8'(k);
        end
        words[1][0] = 8'hA5;
        words[1][1] = 8'h3C;
        words[1][2] = 8'h7E;
        for (int i = 0; i < 4; i++) begin
            wi[i] = 0;
            nw[i] = 1;
        end

        // 1: reset with all requesting, then first grant goes to 0
        rst = 1'b0;
        en  = 4'b1111;
        #12;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_push", q_push, 1'b0);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        tick();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_busy", busy, 1'b1);
        en = 4'b0000;
        settle();
        chk("t1_nopush", q_push, 1'b0);
        tick();
        chk("t1_release", grant, 4'b0000);
        chk("t1_log", plog.size(), 0);

        // 2: producer 1 bursts A5,3C,7E then drops
        wi[1] = 0; nw[1] = 3; en = 4'b0010;
        tick();
        chk("t2_grant", grant, 4'b0010);
        chk("t2_push", q_push, 1'b1);
        chk("t2_ack", ack, 4'b0010);
        chk("t2_data", q_data, 8'hA5);
        tick(); tick(); tick();
        chk("t2_drop_push", q_push, 1'b0);
        chk("t2_drop_ack", ack, 4'b0000);
        tick();
        chk("t2_release", grant, 4'b0000);
        chk("t2_busy", busy, 1'b0);
        chk("t2_fcnt", fcnt, 3);
        chk("t2_q0", fifo[0], 8'hA5);
        chk("t2_q1", fifo[1], 8'h3C);
        chk("t2_q2", fifo[2], 8'h7E);

        // ptr=2 now: 1 and 3 requesting picks 3; releasing 3 brings ptr to 0
        clear_models();
        wi[1] = 0; nw[1] = 1; wi[3] = 0; nw[3] = 1; en = 4'b1010;
        tick();
        chk("t2_ptr2", grant, 4'b1000);
        en = 4'b0000;
        settle();
        tick();

        // 3: producers 0 and 2 together, bursts of 4 with one bubble
        clear_models();
        pull = 1'b1;
        wi[0] = 0; nw[0] = 4; wi[2] = 0; nw[2] = 4; en = 4'b0101;
        tick();
        chk("t3_grant0", grant, 4'b0001);
        chk("t3_ack0", ack, 4'b0001);
        tick(); tick(); tick(); tick();
        chk("t3_bubble", grant, 4'b0000);
        chk("t3_bubble_busy", busy, 1'b0);
        tick();
        chk("t3_grant2", grant, 4'b0100);
        tick(); tick(); tick(); tick();
        chk("t3_release", grant, 4'b0000);
        chk("t3_logn", plog.size(), 8);
        for (int k = 0; k < 4; k++) begin
            chk("t3_order0", plog[k], 8'h01 + 8'(k));
            chk("t3_order2", plog[k+4], 8'h21 + 8'(k));
        end

        // 4: Queue fills, fifth word stalls until one pull
        clear_models();
        pull = 1'b0;
        en = 4'b0000;
        wi[3] = 0; nw[3] = 5; en = 4'b1000;
        tick();
        chk("t4_grant", grant, 4'b1000);
        tick(); tick(); tick(); tick();
        chk("t4_full", fcnt, 4);
        chk("t4_burst_end", grant, 4'b0000);
        tick();
        chk("t4_regrant", grant, 4'b1000);
        chk("t4_stall_push", q_push, 1'b0);
        chk("t4_stall_ack", ack, 4'b0000);
        tick();
        chk("t4_hold_grant", grant, 4'b1000);
        chk("t4_hold_push", q_push, 1'b0);
        pull = 1'b1;
        tick();
        pull = 1'b0;
        settle();
        chk("t4_resume_push", q_push, 1'b1);
        chk("t4_resume_data", q_data, 8'h35);
        chk("t4_resume_ack", ack, 4'b1000);
        tick();
        tick();
        chk("t4_release", grant, 4'b0000);
        chk("t4_logn", plog.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("t4_order", plog[k], 8'h31 + 8'(k));
        end
        chk("t4_front", fifo[0], 8'h32);

        // 5: producer 2 drops after 2 words; ptr moves to 3
        clear_models();
        pull = 1'b1;
        wi[2] = 0; nw[2] = 2; en = 4'b0100;
        tick();
        chk("t5_grant", grant, 4'b0100);
        tick(); tick();
        chk("t5_drop_push", q_push, 1'b0);
        chk("t5_drop_grant", grant, 4'b0100);
        tick();
        chk("t5_release", grant, 4'b0000);
        chk("t5_logn", plog.size(), 2);
        wi[2] = 0; nw[2] = 4; wi[3] = 0; nw[3] = 4; en = 4'b1100;
        tick();
        chk("t5_ptr3", grant, 4'b1000);
        en = 4'b0000;
        settle();
        tick();

        // 6: ptr=3 with requesters 0 and 3
        wi[2] = 0; nw[2] = 4; en = 4'b0100;
        tick();
        chk("t6_setup", grant, 4'b0100);
        en = 4'b0000;
        settle();
        tick();
`ifdef QUEUE_ARB_HIPRI_EN
        exp6 = 4'b0001;
`else
        exp6 = 4'b1000;
`endif
        wi[0] = 0; nw[0] = 1; wi[3] = 0; nw[3] = 1; en = 4'b1001;
        tick();
        chk("t6_grant", grant, exp6);
        en = 4'b0000;
        settle();
        tick();

        // 7: reset mid-burst drops the in-flight word
        clear_models();
        wi[0] = 0; nw[0] = 4; en = 4'b0001;
        tick();
        chk("t7_push", q_push, 1'b1);
        rst = 1'b0;
        settle();
        chk("t7_rst_push", q_push, 1'b0);
        chk("t7_rst_grant", grant, 4'b0000);
        chk("t7_rst_busy", busy, 1'b0);
        tick();
        chk("t7_log", plog.size(), 0);
        rst = 1'b1;
        en  = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
